// File: rtl/instruction_fetch_pkg.sv
// Shared fetch types: FSM state, PC step, default reset vector, FIFO entry.
// No logic of its own; pure declarations plus an alignment helper.
// No backpressure; consumers are the fetch top and its skid buffer.
package kgp_fetch_pkg;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode handshake.
// Pure wiring, no latency.
// Decode backpressure is carried by instrReady against instrValid.
interface instruction_fetch_if;

    logic [31:0] imemAddr;
    logic        imemRe;
    logic [31:0] imemRdata;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic [31:0] instr;
    logic [31:0] pcOut;
    logic        instrValid;
    logic        instrReady;

    modport master (
        output imemAddr, imemRe, instr, pcOut, instrValid,
        input  imemRdata, redirectValid, redirectPc, instrReady
    );

    modport slave (
        input  imemAddr, imemRe, instr, pcOut, instrValid,
        output imemRdata, redirectValid, redirectPc, instrReady
    );

endinterface

// File: rtl/instruction_fetch_skid_buffer.sv
// Two-entry flow-through FIFO of {instr, pc} with synchronous flush.
// Zero latency when empty (write bypasses to the head), otherwise head-of-queue.
// rd_rdy low holds the head stable; the writer must never exceed two entries.
module fetch_skid_buffer
    import kgp_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         wr_vld,
    input  fetch_entry_t wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output fetch_entry_t rd_dat,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         empty;
    logic         pop;
    logic         take;
    logic         store;

    // Head selection: an arriving word is visible at once when nothing is queued.
    always_comb begin
        empty  = (count == 2'd0);
        rd_vld = !empty || wr_vld;
        rd_dat = empty ? wr_dat : mem[rd_ptr];
        pop    = rd_vld && rd_rdy;
        take   = pop && !empty;
        store  = wr_vld && !(empty && pop);
    end

    // Storage and pointers; flush drops every queued entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (take) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, store} - {1'b0, take};
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC sequencing, redirect flush, 2-deep buffering to decode.
// Read issued cycle N, word presented to decode cycle N+1; redirect target valid two cycles later.
// Stalls hold the head and stop reads once buffered+in-flight words reach two. Perf counters under KGP_FETCH_PERF_EN.
module instruction_fetch
    import kgp_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic clk,
    input  logic rst,
    instruction_fetch_if.master bus
`ifdef KGP_FETCH_PERF_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] flushCount
`endif
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  inflight_pc;
    logic         inflight;
    logic [1:0]   buf_count;
    logic         buf_vld;
    fetch_entry_t buf_dat;
    fetch_entry_t wr_dat;
    logic         instr_vld;
    logic         xfer;
    logic         issue;
    logic [2:0]   occ_next;

    assign wr_dat = '{instr: bus.imemRdata, pc: inflight_pc};

    fetch_skid_buffer u_buf (
        .clk    (clk),
        .rst    (rst),
        .flush  (bus.redirectValid),
        .wr_vld (inflight),
        .wr_dat (wr_dat),
        .rd_vld (buf_vld),
        .rd_rdy (bus.instrReady),
        .rd_dat (buf_dat),
        .count  (buf_count)
    );

    // Issue a read only if the buffer can still absorb it after this cycle's arrival and transfer.
    always_comb begin
        instr_vld = !rst && buf_vld;
        xfer      = instr_vld && bus.instrReady;
        occ_next  = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, xfer};
        if (rst || bus.redirectValid) begin
            issue = 1'b0;
        end else if (state == S_RUN) begin
            issue = (occ_next < 3'd2);
        end else begin
            issue = 1'b1;
        end
    end

    assign bus.imemRe     = issue;
    assign bus.imemAddr   = rst ? word_align(RESET_PC) : fetch_pc;
    assign bus.instrValid = instr_vld;
    assign bus.instr      = instr_vld ? buf_dat.instr : 32'h0;
    assign bus.pcOut      = instr_vld ? buf_dat.pc    : 32'h0;

    // Fetch FSM: boot vector, sequential fetch, and redirect flush that squashes the in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_BOOT;
            fetch_pc    <= word_align(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= word_align(RESET_PC);
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
            if (bus.redirectValid) begin
                state    <= S_FLUSH;
                fetch_pc <= word_align(bus.redirectPc);
            end else begin
                case (state)
                    S_BOOT:  state <= S_RUN;
                    S_FLUSH: state <= S_RUN;
                    default: state <= S_RUN;
                endcase
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_INC;
                end
            end
        end
    end

`ifdef KGP_FETCH_PERF_EN
    // Free-running event counters: completed transfers and taken redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchCount <= 32'h0;
            flushCount <= 32'h0;
        end else begin
            if (xfer) begin
                fetchCount <= fetchCount + 32'd1;
            end
            if (bus.redirectValid) begin
                flushCount <= flushCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: program-order scoreboard plus cycle-level checks.
// Stimulus drives #1 after posedge; the monitor samples on negedge.
// Random redirects, stalls and resets follow a directed sequence.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    instruction_fetch_if bus();

`ifdef KGP_FETCH_PERF_EN
    logic [31:0] fetchCount;
    logic [31:0] flushCount;
`endif

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef KGP_FETCH_PERF_EN
        ,
        .fetchCount (fetchCount),
        .flushCount (flushCount)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: a scrambled function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) begin
        bus.imemRdata <= bus.imemRe ? mem_word(bus.imemAddr) : 32'hDEAD_DEAD;
    end

    // Expected program-order stream of PCs.
    logic [31:0] exp_q[$];
    logic [31:0] next_pc;

    // Monitor state
    logic        redir_d1 = 1'b0;
    logic        redir_d2 = 1'b0;
    logic [31:0] tgt_d1 = 32'h0;
    logic [31:0] tgt_d2 = 32'h0;
    logic        stall_prev = 1'b0;
    int          stall_run = 0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    logic [31:0] prev_addr = 32'h0;
    logic        cur_stall;
    logic [31:0] e;
    int          n_xfer = 0;
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_flush = 32'h0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_instrValid", {31'h0, bus.instrValid}, 32'h0);
            chk("rst_imemRe", {31'h0, bus.imemRe}, 32'h0);
            redir_d1   = 1'b0;
            redir_d2   = 1'b0;
            stall_prev = 1'b0;
            stall_run  = 0;
            m_fetch    = 32'h0;
            m_flush    = 32'h0;
        end else begin
`ifdef KGP_FETCH_PERF_EN
            chk("fetchCount", fetchCount, m_fetch);
            chk("flushCount", flushCount, m_flush);
`endif
            if (bus.imemRe) begin
                chk("addr_align", {30'h0, bus.imemAddr[1:0]}, 32'h0);
            end
            if (redir_d1) begin
                chk("redir_n1_valid", {31'h0, bus.instrValid}, 32'h0);
                chk("redir_n1_addr", bus.imemAddr, tgt_d1);
                if (!bus.redirectValid) begin
                    chk("redir_n1_re", {31'h0, bus.imemRe}, 32'h1);
                end
            end
            if (redir_d2 && !redir_d1) begin
                chk("redir_n2_valid", {31'h0, bus.instrValid}, 32'h1);
                chk("redir_n2_pc", bus.pcOut, tgt_d2);
            end
            if (stall_prev) begin
                chk("stall_hold_valid", {31'h0, bus.instrValid}, 32'h1);
                chk("stall_hold_pc", bus.pcOut, prev_pc);
                chk("stall_hold_instr", bus.instr, prev_instr);
            end
            cur_stall = bus.instrValid && !bus.instrReady && !bus.redirectValid;
            if (cur_stall && stall_run >= 2) begin
                chk("full_stall_re", {31'h0, bus.imemRe}, 32'h0);
            end
            if (cur_stall && stall_run >= 3) begin
                chk("full_stall_addr", bus.imemAddr, prev_addr);
            end
            if (bus.instrValid && bus.instrReady) begin
                chk("sb_has_entry", {31'h0, (exp_q.size() != 0)}, 32'h1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("xfer_pc", bus.pcOut, e);
                    chk("xfer_instr", bus.instr, mem_word(e));
                end
                n_xfer++;
                m_fetch = m_fetch + 32'd1;
            end
            if (bus.redirectValid) begin
                m_flush = m_flush + 32'd1;
            end
            redir_d2   = redir_d1;
            tgt_d2     = tgt_d1;
            redir_d1   = bus.redirectValid;
            tgt_d1     = {bus.redirectPc[31:2], 2'b00};
            stall_run  = cur_stall ? stall_run + 1 : 0;
            stall_prev = cur_stall;
            prev_pc    = bus.pcOut;
            prev_instr = bus.instr;
            prev_addr  = bus.imemAddr;
        end
    end

    // Apply inputs for one cycle, then update the expected stream for what that edge did.
    task automatic cycle(input logic rv, input logic [31:0] rp, input logic rd, input logic r);
        rst               = r;
        bus.redirectValid = rv;
        bus.redirectPc    = rp;
        bus.instrReady    = rd;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            next_pc = RST_PC;
        end else if (rv) begin
            exp_q.delete();
            next_pc = {rp[31:2], 2'b00};
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
        #1;
    endtask

    int base;
    logic r_rst;
    logic r_rv;
    logic r_rd;
    logic [31:0] r_tgt;

    initial begin
        rst               = 1'b1;
        bus.redirectValid = 1'b0;
        bus.redirectPc    = 32'h0;
        bus.instrReady    = 1'b0;
        next_pc           = RST_PC;
        #1;
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("reset_instrValid", {31'h0, bus.instrValid}, 32'h0);
        chk("reset_instr", bus.instr, 32'h0);
        chk("reset_pcOut", bus.pcOut, 32'h0);
        chk("reset_imemRe", {31'h0, bus.imemRe}, 32'h0);
        chk("reset_imemAddr", bus.imemAddr, RST_PC);

        // First cycle out of reset issues the reset vector.
        rst            = 1'b0;
        bus.instrReady = 1'b1;
        #2;
        chk("boot_imemRe", {31'h0, bus.imemRe}, 32'h1);
        chk("boot_imemAddr", bus.imemAddr, RST_PC);
        chk("boot_instrValid", {31'h0, bus.instrValid}, 32'h0);
        base = n_xfer;
        repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("boot_stream_rate", n_xfer - base, 32'd11);

        // Five-cycle decode stall mid-stream.
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall5_imemRe", {31'h0, bus.imemRe}, 32'h0);
        base = n_xfer;
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_stall_rate", n_xfer - base, 32'd10);

        // Redirect to an unaligned target.
        cycle(1'b1, 32'h0000_0103, 1'b1, 1'b0);
        chk("redir_instrValid", {31'h0, bus.instrValid}, 32'h0);
        chk("redir_imemAddr", bus.imemAddr, 32'h0000_0100);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("redir_pcOut", bus.pcOut, 32'h0000_0100);
        repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Redirect while full and stalled.
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_2000, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Back-to-back redirects: only the second target is fetched.
        cycle(1'b1, 32'h0000_3000, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_4004, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Address wrap at the top of memory.
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset mid-stream with a read in flight.
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic.
        repeat (3000) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_rv  = !r_rst && ($urandom_range(0, 15) == 0);
            r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
            r_rd  = ($urandom_range(0, 9) < 7);
            cycle(r_rv, r_tgt, r_rd, r_rst);
        end
        repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        chk("total_transfers_seen", {31'h0, (n_xfer > 1000)}, 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000: byte address of the first fetched instruction.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port imemAddr, output, 32: byte address to instruction memory, bits [1:0] always 0.
REQ-005 SHALL have port imemRe, output, 1: read enable; data returns on imemRdata exactly one cycle later.
REQ-006 SHALL have port imemRdata, input, 32: instruction word from memory.
REQ-007 SHALL have port redirectValid, input, 1: jump/branch/jr target is valid this cycle.
REQ-008 SHALL have port redirectPc, input, 32: redirect target; bits [1:0] ignored.
REQ-009 SHALL have port instr, output, 32: instruction word presented to the decode stage.
REQ-010 SHALL have port pcOut, output, 32: byte address of instr.
REQ-011 SHALL have port instrValid, output, 1: instr/pcOut hold a valid instruction.
REQ-012 SHALL have port instrReady, input, 1: decode accepts; transfer occurs when instrValid && instrReady.

Function
REQ-013 SHALL keep a fetch PC; each issued read (imemRe=1) advances it by 4, wrapping 32'hFFFF_FFFC -> 32'h0.
REQ-014 SHALL buffer returned words in a 2-entry FIFO; instr/pcOut show the head entry; instrValid = FIFO non-empty.
REQ-015 SHALL issue a read only when (FIFO occupancy + reads in flight) < 2 in the following cycle's accounting, so no returned word is ever dropped under stall.
REQ-016 SHALL hold instr, pcOut, instrValid stable while instrValid=1 and instrReady=0.
REQ-017 SHALL, with full FIFO and instrReady=0, hold imemRe=0 and imemAddr constant.
REQ-018 SHALL sustain one instruction per cycle when instrReady stays 1 (steady state).
REQ-019 SHALL implement FSM states S_BOOT (first cycle after reset, issue RESET_PC), S_RUN (normal fetch), S_FLUSH (one cycle after redirect, issue target); S_BOOT->S_RUN, S_RUN->S_FLUSH on redirectValid, S_FLUSH->S_RUN unless redirectValid again.
REQ-020 SHALL, on redirectValid in cycle N: empty the FIFO, squash any in-flight read, drive instrValid=0 in N+1, issue imemAddr={redirectPc[31:2],2'b00} in N+1, present that instruction with instrValid=1 in N+2.
REQ-021 SHALL complete a transfer occurring in the same cycle as redirectValid (instruction counts as consumed) before flushing.
REQ-022 SHALL give redirectValid priority over stall; a redirect during a full, stalled FIFO still flushes.
REQ-023 SHALL honour back-to-back redirects; only the most recent target is fetched.

Reset
REQ-024 SHALL, while rst=1: fetch PC=RESET_PC, FIFO empty, in-flight cleared, state S_BOOT, instrValid=0, instr=0, pcOut=0, imemRe=0, imemAddr=RESET_PC.
REQ-025 SHALL, in first cycle with rst=0, issue RESET_PC (imemRe=1); instrValid=1 with pcOut=RESET_PC the next cycle.
REQ-026 SHALL abandon any in-flight read when rst asserts mid-operation; its data is never presented.

Configuration
REQ-027 SHALL, with macro KGP_FETCH_PERF_EN defined, add outputs fetchCount[31:0] (transfers completed) and flushCount[31:0] (redirects taken), both reset to 0, wrapping at 2^32.
REQ-028 SHALL, without KGP_FETCH_PERF_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-029 SHALL place the FSM state enum, PC_INC=4 and the default RESET_PC in shared package kgp_fetch_pkg.
REQ-030 SHALL implement the 2-entry FIFO as sub-module fetch_skid_buffer (32-bit instr + 32-bit pc per entry, flush input).

Verification
REQ-031 Reset release, RESET_PC=0, instrReady=1 -> pcOut 0,4,8,12 on consecutive cycles from cycle 1, instr matching memory.
REQ-032 instrReady=0 for 5 cycles mid-stream -> instr/pcOut frozen, imemRe=0 once FIFO full, no instruction lost or duplicated after release.
REQ-033 redirectValid=1, redirectPc=32'h0000_0103 at cycle N -> instrValid=0 at N+1, imemAddr=32'h100 at N+1, pcOut=32'h100 valid at N+2.
REQ-034 Redirect while FIFO full and instrReady=0 -> both entries discarded, target fetched per REQ-020.
REQ-035 Fetch from 32'hFFFF_FFF8 -> pcOut sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 With KGP_FETCH_PERF_EN: 10 transfers and 2 redirects -> fetchCount=10, flushCount=2; rst mid-run -> both 0.
